decode_field_extract: RTL
=========================

Name: decode_field_extract

Overview:
- Parametrised, pipelined successor to the fixed ModR/M byte picker in decode.
- Takes an aligned instruction-buffer window plus the prefix/opcode summary from the prefix/opcode decoder.
- Locates ModR/M, SIB, displacement and immediate fields, and computes the total instruction length.
- Two-stage valid/ready pipeline between opcode decode and the operand/address-generation stage.

Parameters:
- BUF_BYTES, 16: bytes in the instruction window. Must be at least 16.
- MAX_PREFIX, 4: maximum prefix count accepted.
- MAX_INSTR_LEN, 15: architectural length limit. Longer results set out_err.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- instr_buf  in  8*BUF_BYTES  window; byte i = instr_buf[8*(BUF_BYTES-i)-1 -: 8] (byte 0 at MSB).
- prefix_cnt  in  3  number of prefixes, 0..MAX_PREFIX.
- opc_len  in  2  opcode length, 1 or 2.
- has_modrm  in  1  opcode carries a ModR/M byte.
- imm_size  in  2  immediate size: 0 = none, 1 = 1B, 2 = 2B, 3 = 4B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- modrm  out  8  ModR/M byte, 0 if absent.
- sib  out  8  SIB byte, 0 if absent.
- has_sib  out  1  SIB byte present.
- disp  out  32  sign-extended displacement, 0 if absent.
- imm  out  32  immediate; 8/16-bit values sign-extended.
- instr_len  out  5  total instruction length in bytes.
- out_err  out  1  length exceeds MAX_INSTR_LEN or BUF_BYTES, or input out of range.

Behaviour:
- Reset: s1_valid = s2_valid = 0. out_valid, out_err, has_sib = 0. modrm, sib, disp, imm, instr_len = 0. in_ready = 1 in the cycle after reset deasserts.
- Addressing mode: 32-bit only; no 0x67 handling.
- Stage 1 (on input accept), registers:
  - instr_buf and imm_size.
  - m_off = prefix_cnt + opc_len.
  - ModR/M byte = byte[m_off] when has_modrm, else 0.
- Stage 1 derived fields, with mod = modrm[7:6] and rm = modrm[2:0]:
  - has_sib = has_modrm & mod != 3 & rm == 4.
  - Displacement size: mod 1 gives 1 byte; mod 2 gives 4 bytes; mod 0 with rm 5 gives 4 bytes; otherwise 0.
  - SIB base rule: if mod 0 and SIB[2:0] == 5, displacement size is 4. Stage 1 reads the SIB byte at m_off+1 for this check.
  - d_off = m_off + has_modrm + has_sib.
  - i_off = d_off + dsize.
  - len = i_off + isize, where isize is 0, 1, 2 or 4.
- Stage 2: extracts disp bytes from d_off and imm bytes from i_off.
  - Both fields are little-endian: the lowest-offset byte is the LSB.
  - Both are sign-extended to 32 bits.
  - Drives all outputs from registers.
  - out_err = len > MAX_INSTR_LEN, or len > BUF_BYTES, or prefix_cnt > MAX_PREFIX, or opc_len not in {1, 2}.
  - When out_err = 1, fields reading beyond the window return 0.
- Latency: exactly 2 cycles from input accept to out_valid, with no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - Input beat transfers on in_valid & in_ready.
  - Output beat transfers on out_valid & out_ready.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - in_ready is combinational from out_ready. This is the only comb path; there is no skid buffer.
- Simultaneous events:
  - flush in the same cycle as an input accept: the input is dropped and both valids clear next cycle.
  - reset has priority over flush.
  - reset or flush mid-stall: data is discarded and no out_valid is produced for killed beats.

Decomposition:
- Shared package: imm_size codes, MOD_REG = 3, RM_SIB = 4, RM_DISP32 = 5, BASE_NONE = 5, MAX_INSTR_LEN.
- Shared package function: `isize` decode of imm_size to 0/1/2/4.
- Sub-module byte_window_sel:
  - Parametrised on BUF_BYTES, with an offset input.
  - Returns byte[offset], or 0 when offset >= BUF_BYTES.
  - Instantiated for modrm, sib, disp[0..3] and imm[0..3].

Test Plan:
- 8B 45 08, prefix 0, opc_len 1, has_modrm, imm 0 -> modrm 0x45, has_sib 0, disp 0x00000008, len 3, out_valid 2 cycles after accept.
- 8B 45 F8 -> disp 0xFFFFFFF8, len 3.
- 8B 04 24 -> has_sib 1, sib 0x24, disp 0, len 3.
- 81 05 78 56 34 12 EF BE AD DE, imm_size 3 -> disp 0x12345678, imm 0xDEADBEEF, len 10.
- Prefix 4, opc_len 2, modrm 0x84, SIB, imm_size 3 -> len 16, out_err 1.
- Back-to-back beats with out_ready low for 3 cycles -> in_ready 0 after 2 beats, outputs stable, no loss or duplication. Then flush on a cycle with in_valid -> out_valid 0 next cycle and the flushed beats never appear.

Source files
------------

// File: rtl/decode_field_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module : decode_field_extract_pkg
// Brief  : Shared encodings and helpers for x86 instruction field extraction.
// Rev    : 1.0
// ============================================================================
package decode_field_extract_pkg;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_8    = 2'd1;
  localparam logic [1:0] IMM_16   = 2'd2;
  localparam logic [1:0] IMM_32   = 2'd3;

  localparam logic [1:0] MOD_REG   = 2'd3;
  localparam logic [2:0] RM_SIB    = 3'd4;
  localparam logic [2:0] RM_DISP32 = 3'd5;
  localparam logic [2:0] BASE_NONE = 3'd5;

  localparam int MAX_INSTR_LEN = 15;

  function automatic logic [2:0] isize(input logic [1:0] code);
    case (code)
      IMM_8:   return 3'd1;
      IMM_16:  return 3'd2;
      IMM_32:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_field_extract_if.sv
`default_nettype none
// ============================================================================
// Module : decode_field_extract_if
// Brief  : Input/output beat bundle between opcode decode and operand stages.
// Rev    : 1.0
// ============================================================================
interface decode_field_extract_if #(
  parameter int BUF_BYTES = 16
) ();

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*BUF_BYTES-1:0] instr_buf;
  logic [2:0]             prefix_cnt;
  logic [1:0]             opc_len;
  logic                   has_modrm;
  logic [1:0]             imm_size;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             modrm;
  logic [7:0]             sib;
  logic                   has_sib;
  logic [31:0]            disp;
  logic [31:0]            imm;
  logic [4:0]             instr_len;
  logic                   out_err;

  modport master (
    output flush, in_valid, instr_buf, prefix_cnt, opc_len, has_modrm, imm_size, out_ready,
    input  in_ready, out_valid, modrm, sib, has_sib, disp, imm, instr_len, out_err
  );

  modport slave (
    input  flush, in_valid, instr_buf, prefix_cnt, opc_len, has_modrm, imm_size, out_ready,
    output in_ready, out_valid, modrm, sib, has_sib, disp, imm, instr_len, out_err
  );

endinterface
`default_nettype wire

// File: rtl/decode_field_extract_byte_window_sel.sv
`default_nettype none
// ============================================================================
// Module : byte_window_sel
// Brief  : Picks byte[offset] from an MSB-first window; 0 past the window end.
// Rev    : 1.0
// ============================================================================
module byte_window_sel #(
  parameter int BUF_BYTES = 16,
  parameter int OFF_W     = 6
) (
  input  wire [8*BUF_BYTES-1:0] i_win,
  input  wire [OFF_W-1:0]       i_offset,
  output logic [7:0]            o_byte
);

  always_comb begin
    o_byte = 8'h00;
    for (int i = 0; i < BUF_BYTES; i++) begin
      if (i_offset == OFF_W'(i)) o_byte = i_win[8*(BUF_BYTES-i)-1 -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_field_extract.sv
`default_nettype none
// ============================================================================
// Module : decode_field_extract
// Brief  : Two-stage ModR/M, SIB, displacement and immediate locator/extractor.
// Rev    : 1.0
// ============================================================================
module decode_field_extract #(
  parameter int BUF_BYTES     = 16,
  parameter int MAX_PREFIX    = 4,
  parameter int MAX_INSTR_LEN = decode_field_extract_pkg::MAX_INSTR_LEN
) (
  input wire                    clk,
  input wire                    reset,
  decode_field_extract_if.slave bus
);
  import decode_field_extract_pkg::*;

  // Two spare bits keep offset sums past the window from wrapping back into it.
  localparam int OFF_W = $clog2(BUF_BYTES) + 2;
  typedef logic [OFF_W-1:0] off_t;

  logic                   s1_valid_q, s1_valid_d;
  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic [1:0]             imm_size_q, imm_size_d;
  off_t                   m_off_q, m_off_d;
  logic                   has_modrm_q, has_modrm_d;
  logic [7:0]             modrm1_q, modrm1_d;
  logic                   in_err_q, in_err_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [7:0]             modrm_q, modrm_d;
  logic [7:0]             sib_q, sib_d;
  logic                   has_sib_q, has_sib_d;
  logic [31:0]            disp_q, disp_d;
  logic [31:0]            imm_q, imm_d;
  logic [4:0]             len_q, len_d;
  logic                   err_q, err_d;

  logic       s1_adv, in_ready, in_fire;
  off_t       m_off_in, d_off, i_off, len_w;
  logic [7:0] modrm_raw, sib_raw;
  logic [1:0] mod_f;
  logic [2:0] rm_f, dsize, isz;
  logic       has_sib_w, err_w;
  logic [7:0] disp_b [4];
  logic [7:0] imm_b  [4];

  assign s1_adv   = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = bus.in_valid && in_ready;
  assign m_off_in = off_t'(bus.prefix_cnt) + off_t'(bus.opc_len);

  byte_window_sel #(.BUF_BYTES(BUF_BYTES), .OFF_W(OFF_W)) u_modrm_sel (
    .i_win(bus.instr_buf), .i_offset(m_off_in), .o_byte(modrm_raw));

  byte_window_sel #(.BUF_BYTES(BUF_BYTES), .OFF_W(OFF_W)) u_sib_sel (
    .i_win(buf_q), .i_offset(m_off_q + off_t'(1)), .o_byte(sib_raw));

  generate
    for (genvar k = 0; k < 4; k++) begin : g_field_bytes
      byte_window_sel #(.BUF_BYTES(BUF_BYTES), .OFF_W(OFF_W)) u_disp_sel (
        .i_win(buf_q), .i_offset(d_off + off_t'(k)), .o_byte(disp_b[k]));
      byte_window_sel #(.BUF_BYTES(BUF_BYTES), .OFF_W(OFF_W)) u_imm_sel (
        .i_win(buf_q), .i_offset(i_off + off_t'(k)), .o_byte(imm_b[k]));
    end
  endgenerate

  // Field geometry of the beat held in stage 1.
  always_comb begin
    mod_f     = modrm1_q[7:6];
    rm_f      = modrm1_q[2:0];
    has_sib_w = has_modrm_q && (mod_f != MOD_REG) && (rm_f == RM_SIB);
    dsize     = 3'd0;
    if (has_modrm_q) begin
      case (mod_f)
        2'd1:    dsize = 3'd1;
        2'd2:    dsize = 3'd4;
        2'd0:    if (rm_f == RM_DISP32 || (has_sib_w && sib_raw[2:0] == BASE_NONE)) dsize = 3'd4;
        default: dsize = 3'd0;
      endcase
    end
    isz   = isize(imm_size_q);
    d_off = m_off_q + off_t'(has_modrm_q) + off_t'(has_sib_w);
    i_off = d_off + off_t'(dsize);
    len_w = i_off + off_t'(isz);
    err_w = in_err_q || (int'(len_w) > MAX_INSTR_LEN) || (int'(len_w) > BUF_BYTES);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    buf_d       = buf_q;
    imm_size_d  = imm_size_q;
    m_off_d     = m_off_q;
    has_modrm_d = has_modrm_q;
    modrm1_d    = modrm1_q;
    in_err_d    = in_err_q;
    s2_valid_d  = s2_valid_q;
    modrm_d     = modrm_q;
    sib_d       = sib_q;
    has_sib_d   = has_sib_q;
    disp_d      = disp_q;
    imm_d       = imm_q;
    len_d       = len_q;
    err_d       = err_q;

    if (in_ready) s1_valid_d = bus.in_valid;
    if (in_fire) begin
      buf_d       = bus.instr_buf;
      imm_size_d  = bus.imm_size;
      m_off_d     = m_off_in;
      has_modrm_d = bus.has_modrm;
      modrm1_d    = bus.has_modrm ? modrm_raw : 8'h00;
      in_err_d    = (int'(bus.prefix_cnt) > MAX_PREFIX) ||
                    (bus.opc_len != 2'd1 && bus.opc_len != 2'd2);
    end

    if (s1_adv) s2_valid_d = s1_valid_q;
    if (s1_adv && s1_valid_q) begin
      modrm_d   = modrm1_q;
      sib_d     = has_sib_w ? sib_raw : 8'h00;
      has_sib_d = has_sib_w;
      case (dsize)
        3'd1:    disp_d = {{24{disp_b[0][7]}}, disp_b[0]};
        3'd4:    disp_d = {disp_b[3], disp_b[2], disp_b[1], disp_b[0]};
        default: disp_d = 32'h0;
      endcase
      case (isz)
        3'd1:    imm_d = {{24{imm_b[0][7]}}, imm_b[0]};
        3'd2:    imm_d = {{16{imm_b[1][7]}}, imm_b[1], imm_b[0]};
        3'd4:    imm_d = {imm_b[3], imm_b[2], imm_b[1], imm_b[0]};
        default: imm_d = 32'h0;
      endcase
      len_d = len_w[4:0];
      err_d = err_w;
    end

    if (bus.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      buf_q       <= '0;
      imm_size_q  <= 2'd0;
      m_off_q     <= '0;
      has_modrm_q <= 1'b0;
      modrm1_q    <= 8'h00;
      in_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      modrm_q     <= 8'h00;
      sib_q       <= 8'h00;
      has_sib_q   <= 1'b0;
      disp_q      <= 32'h0;
      imm_q       <= 32'h0;
      len_q       <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      buf_q       <= buf_d;
      imm_size_q  <= imm_size_d;
      m_off_q     <= m_off_d;
      has_modrm_q <= has_modrm_d;
      modrm1_q    <= modrm1_d;
      in_err_q    <= in_err_d;
      s2_valid_q  <= s2_valid_d;
      modrm_q     <= modrm_d;
      sib_q       <= sib_d;
      has_sib_q   <= has_sib_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.modrm     = modrm_q;
  assign bus.sib       = sib_q;
  assign bus.has_sib   = has_sib_q;
  assign bus.disp      = disp_q;
  assign bus.imm       = imm_q;
  assign bus.instr_len = len_q;
  assign bus.out_err   = err_q;

endmodule
`default_nettype wire
